// File: rtl/router_8_to_1_rr.sv
// ---------------------------------------------------------------------------
// router_8_to_1_rr
//   Merges 8 valid/ready source channels onto one output channel. A source is
//   picked round-robin, then holds the grant until its last beat is accepted,
//   so packets are never interleaved. The output is one registered stage that
//   also carries the index of the source the beat came from.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant held; arbitrate when enable=1 and a source is valid
//   BUSY    | grant held; forward beats from the granted source until last
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   enable              permits new grants (a packet in flight always completes)
//   in_valid/in_data/in_last/in_ready   8 source channels, data of source i
//                                       at in_data[i*DW +: DW]
//   out_valid/out_data/out_last/out_src/out_ready   merged output channel
//   busy                high while a grant is held
//   pkt_count           packets completed at the output, wraps
// ---------------------------------------------------------------------------
module router_8_to_1_rr #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [7:0]      in_valid,
    input  logic [8*DW-1:0] in_data,
    input  logic [7:0]      in_last,
    output logic [7:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [2:0]      out_src,
    input  logic            out_ready,
    output logic            busy,
    output logic [CW-1:0]   pkt_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [2:0]      out_src_q, out_src_d;
    logic [CW-1:0]   pkt_count_q, pkt_count_d;

    logic            pick_found;
    logic [2:0]      pick_idx;
    logic            out_space;
    logic            accept;
    logic            beat_last;
    logic [DW-1:0]   beat_data;

    // Round-robin pick: first valid source at rr_ptr, rr_ptr+1, ... (3-bit wrap)
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = 0; k < 8; k++) begin
            if (!pick_found && in_valid[rr_ptr_q + 3'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_ptr_q + 3'(k);
            end
        end
    end

    // The output stage can take a beat when empty or draining this cycle.
    assign out_space = !out_valid_q || out_ready;
    assign beat_data = in_data[grant_q*DW +: DW];
    assign beat_last = in_last[grant_q];
    assign accept    = (state_q == ST_BUSY) && in_valid[grant_q] && out_space;
    assign in_ready  = ((state_q == ST_BUSY) && out_space) ? (8'b1 << grant_q) : 8'b0;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && beat_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_src_d   = grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && out_last_q) begin
            pkt_count_d = pkt_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'd0;
            rr_ptr_q    <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 3'd0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == ST_BUSY);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_8_to_1_rr.sv
// ---------------------------------------------------------------------------
// tb_router_8_to_1_rr
//   Directed bench for router_8_to_1_rr. Each source is a small beat buffer
//   that presents its head beat and pops it on a handshake; output beats are
//   logged and compared with hand-written expected sequences. Inputs change
//   1 time unit after the rising edge, checks are made 2 units after it.
// ---------------------------------------------------------------------------
module tb_router_8_to_1_rr;

    localparam int DW = 8;
    localparam int CW = 16;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [7:0]      in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]      in_last;
    logic [7:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [2:0]      out_src;
    logic            out_ready;
    logic            busy;
    logic [CW-1:0]   pkt_count;

    router_8_to_1_rr #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] bdata [8][16];
    logic       blast [8][16];
    int         head  [8];
    int         tail  [8];

    logic [2:0] log_src  [64];
    logic [7:0] log_data [64];
    logic       log_last [64];
    int         log_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        bdata[s][tail[s]] = d;
        blast[s][tail[s]] = l;
        tail[s]++;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 8; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            if (head[i] < tail[i]) begin
                in_valid[i]        = 1'b1;
                in_data[i*DW +: DW] = bdata[i][head[i]];
                in_last[i]         = blast[i][head[i]];
            end else begin
                in_valid[i]        = 1'b0;
                in_data[i*DW +: DW] = 8'h00;
                in_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at the falling edge, advance at the rising edge.
    task automatic tick();
        logic [7:0] fire;
        logic       ofire;
        logic [2:0] s;
        logic [7:0] d;
        logic       l;
        @(negedge clk);
        fire  = in_valid & in_ready;
        ofire = out_valid & out_ready;
        s = out_src;
        d = out_data;
        l = out_last;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (fire[i]) head[i]++;
        end
        if (ofire && log_n < 64) begin
            log_src[log_n]  = s;
            log_data[log_n] = d;
            log_last[log_n] = l;
            log_n++;
        end
        drive();
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = busy || out_valid;
        for (int i = 0; i < 8; i++) begin
            if (head[i] < tail[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [2:0] s,
                             input logic [7:0] d, input logic l);
        if (idx >= log_n) check(tag, 32'hDEAD, {20'd0, s, l, d});
        else check(tag, {20'd0, log_src[idx], log_last[idx], log_data[idx]}, {20'd0, s, l, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb;
        clear_srcs();
        rst_n     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1; drive(); #1;

        // Single source, 3-beat packet from source 2
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        drive(); #1;
        check("s3_rdy_idle", 32'(in_ready), 32'h00);
        tick();
        check("s3_rdy_grant", 32'(in_ready), 32'h04);
        check("s3_busy", 32'(busy), 32'd1);
        tick();
        check("s3_b0", {21'd0, out_valid, out_src, out_last, out_data}, {21'd0, 1'b1, 3'd2, 1'b0, 8'h11});
        tick();
        check("s3_b1", {21'd0, out_valid, out_src, out_last, out_data}, {21'd0, 1'b1, 3'd2, 1'b0, 8'h22});
        tick();
        check("s3_b2", {21'd0, out_valid, out_src, out_last, out_data}, {21'd0, 1'b1, 3'd2, 1'b1, 8'h33});
        check("s3_idle", 32'(busy), 32'd0);
        tick();
        check("s3_pkt", 32'(pkt_count), 32'd1);
        check("s3_drained", 32'(out_valid), 32'd0);

        // Reset while BUSY with 0x5A held at the output
        out_ready = 1'b0;
        push(6, 8'h5A, 1'b0);
        push(6, 8'h5B, 1'b1);
        drive(); #1;
        tick();
        check("rm_rdy", 32'(in_ready), 32'h40);
        tick();
        check("rm_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
        check("rm_rdy_stall", 32'(in_ready), 32'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", 32'(out_valid), 32'd0);
        check("rm_in_ready", 32'(in_ready), 32'h00);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_pkt_count", 32'(pkt_count), 32'd0);
        clear_srcs();
        drive();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1; drive(); #1;
        check("rm_after_busy", 32'(busy), 32'd0);

        // Round-robin fairness: every source offers two 1-beat packets
        lb = log_n;
        for (int i = 0; i < 8; i++) begin
            push(i, 8'(i), 1'b1);
            push(i, 8'(i), 1'b1);
        end
        drive(); #1;
        tick();
        check("rr_first_grant", 32'(in_ready), 32'h01);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rr_out%0d", k), {21'd0, out_valid, out_src, out_last, out_data},
                  {21'd0, 1'b1, 3'(k % 8), 1'b1, 8'(k % 8)});
            tick();
            check($sformatf("rr_bubble%0d", k), 32'(out_valid), 32'd0);
            if (k == 7) check("rr_pkt8", 32'(pkt_count), 32'd8);
        end
        drain("rr_drain");
        for (int k = 0; k < 16; k++) begin
            check_log($sformatf("rr_log%0d", k), lb + k, 3'(k % 8), 8'(k % 8), 1'b1);
        end
        check("rr_pkt16", 32'(pkt_count), 32'd16);

        // Backpressure on a 4-beat packet from source 5
        lb = log_n;
        for (int b = 0; b < 4; b++) push(5, 8'hA0 + 8'(b), (b == 3));
        drive(); #1;
        tick();
        check("bp_rdy", 32'(in_ready), 32'h20);
        tick();
        check("bp_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA0});
        out_ready = 1'b0;
        #1;
        check("bp_rdy_stall0", 32'(in_ready), 32'h00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA0});
            check($sformatf("bp_rdy_stall%0d", c + 1), 32'(in_ready), 32'h00);
        end
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", 32'(log_n - lb), 32'd4);
        for (int b = 0; b < 4; b++) begin
            check_log($sformatf("bp_log%0d", b), lb + b, 3'd5, 8'hA0 + 8'(b), (b == 3));
        end

        // No interleave: source 0 requests while source 1 is mid-packet
        lb = log_n;
        for (int b = 0; b < 4; b++) push(1, 8'h10 + 8'(b), (b == 3));
        drive(); #1;
        tick();
        tick();
        tick();
        push(0, 8'h00, 1'b1);
        drive(); #1;
        check("ni_rdy", 32'(in_ready), 32'h02);
        check("ni_busy", 32'(busy), 32'd1);
        drain("ni_drain");
        for (int b = 0; b < 4; b++) begin
            check_log($sformatf("ni_log%0d", b), lb + b, 3'd1, 8'h10 + 8'(b), (b == 3));
        end
        check_log("ni_log_src0", lb + 4, 3'd0, 8'h00, 1'b1);

        // Enable gating: drop enable while source 3 is mid-packet, source 4 waiting
        lb = log_n;
        for (int b = 0; b < 4; b++) push(3, 8'h30 + 8'(b), (b == 3));
        drive(); #1;
        tick();
        tick();
        check("en_first", {21'd0, out_valid, out_src, out_last, out_data}, {21'd0, 1'b1, 3'd3, 1'b0, 8'h30});
        enable = 1'b0;
        push(4, 8'h40, 1'b1);
        drive(); #1;
        tick();
        check("en_busy_mid", 32'(busy), 32'd1);
        tick();
        tick();
        check("en_busy_fall", 32'(busy), 32'd0);
        tick();
        check("en_no_grant", {23'd0, busy, in_ready}, 32'd0);
        tick();
        check("en_still_idle", 32'(busy), 32'd0);
        check("en_src4_waiting", 32'(in_valid), 32'h10);
        enable = 1'b1;
        #1;
        tick();
        check("en_grant4", {23'd0, busy, in_ready}, {23'd0, 1'b1, 8'h10});
        drain("en_drain");
        for (int b = 0; b < 4; b++) begin
            check_log($sformatf("en_log%0d", b), lb + b, 3'd3, 8'h30 + 8'(b), (b == 3));
        end
        check_log("en_log_src4", lb + 4, 3'd4, 8'h40, 1'b1);
        check("final_pkt", 32'(pkt_count), 32'd21);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/router_8_to_1_rr.md
Name: router_8_to_1_rr

Overview:
- Merge point: 8 independent source channels onto one shared output channel.
- Inverse of the 1-to-8 router: packets from sources 0..7 are arbitrated round-robin and forwarded beat-by-beat with valid/ready handshakes.
- The grant stays locked to one source until that source's last beat is accepted, so packets never interleave.
- Output is a single registered stage carrying the source index alongside the data.

Parameters:
- DW, 8, data width per beat
- CW, 16, width of completed-packet counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new grants; a packet in progress always completes
- in_valid  in  8  per-source beat valid
- in_data  in  8*DW  per-source data, source i at bits [i*DW +: DW]
- in_last  in  8  per-source last-beat flag
- in_ready  out  8  per-source accept, one-hot or zero
- out_valid  out  1  output beat valid
- out_data  out  DW  output beat data
- out_last  out  1  output last-beat flag
- out_src  out  3  index of the source of the current output beat
- out_ready  in  1  downstream accept
- busy  out  1  high while a grant is held
- pkt_count  out  CW  count of packets completed at the output, wraps

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, grant=0, rr_ptr=0
  - out_valid=0, out_data=0, out_last=0, out_src=0
  - busy=0, pkt_count=0
  - in_ready is combinational, therefore 0.
- Handshake:
  - Beat transfer on any channel = valid & ready in the same cycle.
  - Sources hold valid, data and last stable until accepted.
  - The output holds out_valid, out_data, out_last and out_src stable while out_valid=1 and out_ready=0.
- FSM IDLE:
  - If enable=1 and any in_valid is set, register grant = first set in_valid searching rr_ptr, rr_ptr+1, ... (mod 8); go to BUSY.
  - No in_ready is asserted in IDLE, so there is 1 arbitration bubble cycle per packet.
- FSM BUSY:
  - in_ready[grant] = (!out_valid | out_ready); all other in_ready bits = 0.
  - On an accepted beat: the output register loads data, last and src=grant, and out_valid=1 next cycle. Latency input to output = 1 cycle.
  - If the accepted beat has last=1: go to IDLE and set rr_ptr = grant+1 mod 8 (7 wraps to 0).
- Output drain:
  - If out_valid & out_ready and no new beat is loaded that cycle, out_valid=0.
  - Load and drain in the same cycle means out_valid stays 1 with new contents, giving full throughput of 1 beat/cycle within a packet.
- pkt_count: increments by 1 on each cycle with out_valid & out_ready & out_last; wraps from 2^CW-1 to 0.
- busy: equals (state==BUSY).
- enable deasserted:
  - In IDLE, no grant is issued.
  - In BUSY, no effect; the current packet completes, then the block waits in IDLE.
- Simultaneous requests: only the round-robin winner is granted; the others wait with valid held, and no beat is lost.
- Granted source dropping valid mid-packet: the grant is held and the block stalls in BUSY until the next beat arrives. There is no timeout.
- Single-beat packet (valid & last together): BUSY lasts 1 accept, then IDLE.
- Reset mid-packet: all state clears immediately. The partial packet is discarded at the output and the upstream source must resend.
- in_last on non-granted channels is ignored.

Test Plan:
- Reset:
  - rst_n=0 asynchronously mid-cycle during BUSY, with out_valid=1 holding data 0x5A.
  - Response: out_valid=0, in_ready=0x00, busy=0 and pkt_count=0 immediately; after release the FSM is in IDLE with rr_ptr=0.
- Single source, 3-beat packet:
  - Source 2 sends 0x11, 0x22, 0x33 (last on 0x33); out_ready=1.
  - Response: in_ready=0x04 from the cycle after the request; out_data = 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after acceptance, with out_src=2 and out_last only on 0x33; pkt_count=1.
- Round-robin fairness:
  - All 8 sources continuously send 1-beat packets with data = index; out_ready=1.
  - Response: out_src sequence 0,1,2,...,7,0; one bubble cycle between packets; pkt_count=8 after 8 packets.
- Backpressure:
  - Source 5 sends a 4-beat packet; out_ready=0 for 3 cycles after the first beat appears.
  - Response: out_data holds the first beat and in_ready[5]=0 while stalled; all 4 beats are delivered in order with none dropped or duplicated.
- No interleave:
  - Source 1 is mid-packet (2 of 4 beats sent) when source 0 asserts valid.
  - Response: source 1 finishes all 4 beats first; source 0 is granted next with out_src=0; rr_ptr=2 after source 1 completes.
- Enable gating:
  - Set enable=0 while source 3 is mid-packet and source 4 is requesting.
  - Response: source 3's packet completes, busy falls and source 4 is not granted; enable=1 brings a grant to source 4 within 2 cycles.
